draw_packet_decoder: RTL and testbench

Assembles 4-byte draw commands arriving from the SPI byte receiver into single pixel-write requests for the pixel store's write port. It sits between the SPI slave (upstream, one byte per strobe) and `pixelStore` (downstream, consumes x/y/color/brush). It resynchronises on framing errors and byte-gap timeouts, and counts dropped commands.

---
 rtl/draw_packet_decoder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_draw_packet_decoder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_packet_decoder.sv
// -----------------------------------------------------------------------------
// draw_packet_decoder
//
// Assembles 4-byte draw commands from the SPI byte receiver into single
// pixel-write requests for the pixel store.
//
// Packet byte order:
//   B0 = {3'b101, brush, rsvd, color[2:0]}
//   B1 = {rsvd[3:0], y[9:8], x[9:8]}
//   B2 = x[7:0]
//   B3 = y[7:0]
//
// The parser resynchronises on a bad header marker, on a byte-gap timeout and
// on frame_start. It counts sync errors and dropped packets, and both counts
// saturate at 255.
//
// Ports:
//   clk          in   pixel-domain clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   chip-select pulse; forces header state
//   byte_valid   in   byte strobe
//   byte_data    in   received byte
//   wr_valid     out  write request pending (registered)
//   wr_ready     in   pixel store accepts request this cycle
//   wr_x, wr_y   out  pixel coordinates
//   wr_color     out  colour code
//   wr_brush     out  1 = paint, 0 = erase
//   sync_err_cnt out  saturating count of bad headers / timeouts / aborts
//   drop_cnt     out  saturating count of out-of-range / overflowed packets
// -----------------------------------------------------------------------------
module draw_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int X_MAX          = 640,
    parameter int Y_MAX          = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [9:0] wr_x,
    output logic [9:0] wr_y,
    output logic [2:0] wr_color,
    output logic       wr_brush,
    output logic [7:0] sync_err_cnt,
    output logic [7:0] drop_cnt
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [9:0]        X_LIMIT    = 10'(X_MAX);
    localparam logic [9:0]        Y_LIMIT    = 10'(Y_MAX);

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_B1  = 2'd1,
        ST_B2  = 2'd2,
        ST_B3  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Partial packet fields
    logic       brush_q, brush_d;
    logic [2:0] color_q, color_d;
    logic [1:0] xhi_q, xhi_d;
    logic [1:0] yhi_q, yhi_d;
    logic [7:0] xlo_q, xlo_d;

    // Output request register and counters
    logic       wr_valid_q, wr_valid_d;
    logic [9:0] wr_x_q, wr_x_d;
    logic [9:0] wr_y_q, wr_y_d;
    logic [2:0] wr_color_q, wr_color_d;
    logic       wr_brush_q, wr_brush_d;
    logic [7:0] sync_q, sync_d;
    logic [7:0] drop_q, drop_d;

    // Decoded events
    logic       hdr_ok_s;
    logic [IDLE_W-1:0] idle_inc_s;
    logic       timeout_s;
    logic       complete_s;
    logic [9:0] pkt_x_s;
    logic [9:0] pkt_y_s;
    logic       in_range_s;
    logic       load_s;
    logic       drop_ev_s;
    logic       sync_ev_s;

    assign hdr_ok_s   = (byte_data[7:5] == 3'b101);
    assign idle_inc_s = idle_q + IDLE_ONE;
    // Timeout only counts cycles with neither a byte nor a frame restart.
    assign timeout_s  = (state_q != ST_HDR) && !frame_start && !byte_valid &&
                        (idle_inc_s == IDLE_LIMIT);
    assign complete_s = (state_q == ST_B3) && byte_valid && !frame_start;
    assign pkt_x_s    = {xhi_q, xlo_q};
    assign pkt_y_s    = {yhi_q, byte_data};
    assign in_range_s = (pkt_x_s < X_LIMIT) && (pkt_y_s < Y_LIMIT);
    // The output slot is free when empty or being drained on this edge.
    assign load_s     = complete_s && in_range_s && (!wr_valid_q || wr_ready);
    assign drop_ev_s  = complete_s && (!in_range_s || (wr_valid_q && !wr_ready));
    // A frame restart inside a packet, a bad header, and a timeout all count
    // as a single sync event even when coincident.
    assign sync_ev_s  = (frame_start && (state_q != ST_HDR)) ||
                        (byte_valid && !hdr_ok_s &&
                         (frame_start || (state_q == ST_HDR))) ||
                        timeout_s;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a coincident frame_start makes the byte a header
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            if (byte_valid && hdr_ok_s) begin
                state_d = ST_B1;
            end else begin
                state_d = ST_HDR;
            end
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (byte_valid && hdr_ok_s) begin
                        state_d = ST_B1;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_B1: begin
                    if (byte_valid) begin
                        state_d = ST_B2;
                    end else if (timeout_s) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_B1;
                    end
                end
                ST_B2: begin
                    if (byte_valid) begin
                        state_d = ST_B3;
                    end else if (timeout_s) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_B2;
                    end
                end
                ST_B3: begin
                    if (byte_valid || timeout_s) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_B3;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    // Datapath next values: idle counter, field capture, output slot, counters
    always_comb begin
        idle_d     = idle_q;
        brush_d    = brush_q;
        color_d    = color_q;
        xhi_d      = xhi_q;
        yhi_d      = yhi_q;
        xlo_d      = xlo_q;
        wr_valid_d = wr_valid_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        wr_brush_d = wr_brush_q;
        sync_d     = sync_q;
        drop_d     = drop_q;

        if ((state_d == ST_HDR) || byte_valid || frame_start) begin
            idle_d = {IDLE_W{1'b0}};
        end else begin
            idle_d = idle_inc_s;
        end

        if (frame_start) begin
            brush_d = 1'b0;
            color_d = 3'd0;
            xhi_d   = 2'd0;
            yhi_d   = 2'd0;
            xlo_d   = 8'd0;
            if (byte_valid && hdr_ok_s) begin
                brush_d = byte_data[4];
                color_d = byte_data[2:0];
            end else begin
                brush_d = 1'b0;
            end
        end else if (byte_valid) begin
            case (state_q)
                ST_HDR: begin
                    if (hdr_ok_s) begin
                        brush_d = byte_data[4];
                        color_d = byte_data[2:0];
                    end else begin
                        brush_d = brush_q;
                    end
                end
                ST_B1: begin
                    xhi_d = byte_data[1:0];
                    yhi_d = byte_data[3:2];
                end
                ST_B2:   xlo_d = byte_data;
                ST_B3:   xlo_d = xlo_q;
                default: xlo_d = xlo_q;
            endcase
        end else begin
            xlo_d = xlo_q;
        end

        if (load_s) begin
            wr_valid_d = 1'b1;
            wr_x_d     = pkt_x_s;
            wr_y_d     = pkt_y_s;
            wr_color_d = color_q;
            wr_brush_d = brush_q;
        end else if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end else begin
            wr_valid_d = wr_valid_q;
        end

        if (sync_ev_s && (sync_q != 8'hFF)) begin
            sync_d = sync_q + 8'd1;
        end else begin
            sync_d = sync_q;
        end

        if (drop_ev_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q     <= {IDLE_W{1'b0}};
            brush_q    <= 1'b0;
            color_q    <= 3'd0;
            xhi_q      <= 2'd0;
            yhi_q      <= 2'd0;
            xlo_q      <= 8'd0;
            wr_valid_q <= 1'b0;
            wr_x_q     <= 10'd0;
            wr_y_q     <= 10'd0;
            wr_color_q <= 3'd0;
            wr_brush_q <= 1'b0;
            sync_q     <= 8'd0;
            drop_q     <= 8'd0;
        end else begin
            idle_q     <= idle_d;
            brush_q    <= brush_d;
            color_q    <= color_d;
            xhi_q      <= xhi_d;
            yhi_q      <= yhi_d;
            xlo_q      <= xlo_d;
            wr_valid_q <= wr_valid_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
            wr_brush_q <= wr_brush_d;
            sync_q     <= sync_d;
            drop_q     <= drop_d;
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_x         = wr_x_q;
    assign wr_y         = wr_y_q;
    assign wr_color     = wr_color_q;
    assign wr_brush     = wr_brush_q;
    assign sync_err_cnt = sync_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_draw_packet_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for draw_packet_decoder: scoreboard queue filled by the stimulus,
// drained by a negedge monitor whenever a request retires.
// -----------------------------------------------------------------------------
module tb_draw_packet_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [2:0] wr_color;
    logic       wr_brush;
    logic [7:0] sync_err_cnt;
    logic [7:0] drop_cnt;

    draw_packet_decoder #(
        .TIMEOUT_CYCLES(1024),
        .X_MAX(640),
        .Y_MAX(480)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_color(wr_color),
        .wr_brush(wr_brush),
        .sync_err_cnt(sync_err_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        logic       b;
    } req_t;

    req_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_sync = 0;
    int   exp_drop = 0;
    bit   slot_busy = 1'b0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: compares every retiring request and checks hold stability
    req_t held;
    bit   held_v = 1'b0;
    req_t e;
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (held_v) begin
                chk("hold_valid", int'(wr_valid), 1);
                chk("hold_stable", int'({wr_x, wr_y, wr_color, wr_brush} == held), 1);
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_x", int'(wr_x), int'(e.x));
                    chk("wr_y", int'(wr_y), int'(e.y));
                    chk("wr_color", int'(wr_color), int'(e.c));
                    chk("wr_brush", int'(wr_brush), int'(e.b));
                end
                held_v = 1'b0;
            end else if (wr_valid) begin
                held_v = 1'b1;
                held   = {wr_x, wr_y, wr_color, wr_brush};
            end else begin
                held_v = 1'b0;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // Random back-pressure source
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fs);
        byte_valid  = 1'b1;
        byte_data   = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        byte_data   = 8'h00;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    function automatic logic [31:0] enc(input logic b, input logic [2:0] c,
                                        input logic [9:0] x, input logic [9:0] y,
                                        input logic [4:0] rsv);
        return {3'b101, b, rsv[4], c, rsv[3:0], y[9:8], x[9:8], x[7:0], y[7:0]};
    endfunction

    // Reference model: decide the fate of a whole packet from its fields
    task automatic send_pkt(input logic b, input logic [2:0] c, input int x,
                            input int y, input logic [4:0] rsv, input int gap);
        logic [31:0] w;
        req_t r;
        w = enc(b, c, 10'(x), 10'(y), rsv);
        send_byte(w[31:24], 1'b0);
        idle(gap);
        send_byte(w[23:16], 1'b0);
        idle(gap);
        send_byte(w[15:8], 1'b0);
        idle(gap);
        if (x >= 640 || y >= 480 || slot_busy) begin
            exp_drop++;
        end else begin
            r = '{x: 10'(x), y: 10'(y), c: c, b: b};
            exp_q.push_back(r);
        end
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_sync"}, int'(sync_err_cnt), (exp_sync > 255) ? 255 : exp_sync);
        chk({tag, "_drop"}, int'(drop_cnt), (exp_drop > 255) ? 255 : exp_drop);
    endtask

    initial begin
        logic [7:0]  bb;
        logic [31:0] w;
        int          k;
        int          r;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        wr_ready    = 1'b0;
        #23;
        chk("rst_valid", int'(wr_valid), 0);
        chk("rst_x", int'(wr_x), 0);
        chk("rst_y", int'(wr_y), 0);
        chk("rst_color", int'(wr_color), 0);
        chk("rst_brush", int'(wr_brush), 0);
        chk("rst_sync", int'(sync_err_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic decode from raw bytes
        wr_ready = 1'b1;
        exp_q.push_back('{x: 10'd300, y: 10'd224, c: 3'd5, b: 1'b0});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hE0, 1'b0);
        idle(3);
        chk("t1_empty", exp_q.size(), 0);
        chk_cnt("t1");

        // Range edge: x=639/y=479 accepted, x=640 dropped
        send_pkt(1'b1, 3'd2, 639, 479, 5'd0, 0);
        send_pkt(1'b1, 3'd2, 640, 0, 5'd0, 0);
        idle(3);
        chk_cnt("t2");
        send_pkt(1'b0, 3'd1, 0, 480, 5'd0, 0);
        idle(2);
        chk_cnt("t2y");

        // Overflow while held
        wr_ready = 1'b0;
        send_pkt(1'b0, 3'd7, 10, 20, 5'd0, 0);
        slot_busy = 1'b1;
        send_pkt(1'b1, 3'd1, 30, 40, 5'd0, 0);
        idle(5);
        chk("t3_held", int'(wr_valid), 1);
        chk_cnt("t3");
        slot_busy = 1'b0;
        wr_ready  = 1'b1;
        idle(3);
        chk("t3_empty", exp_q.size(), 0);
        chk("t3_valid", int'(wr_valid), 0);

        // Bad header then valid packet
        send_byte(8'h40, 1'b0);
        exp_sync++;
        send_pkt(1'b1, 3'd3, 123, 45, 5'd0, 0);
        idle(3);
        chk_cnt("t4");

        // Timeout after exactly 1024 idle cycles
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(1024);
        exp_sync++;
        send_pkt(1'b0, 3'd4, 500, 400, 5'd0, 0);
        idle(3);
        chk_cnt("t5");

        // 1023 idle cycles is still inside the packet
        exp_q.push_back('{x: 10'd300, y: 10'd224, c: 3'd5, b: 1'b0});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(1023);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hE0, 1'b0);
        idle(3);
        chk("t5b_empty", exp_q.size(), 0);
        chk_cnt("t5b");

        // frame_start coincident with a header mid-packet
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h2C, 1'b0);
        exp_sync++;
        exp_q.push_back('{x: 10'd300, y: 10'd224, c: 3'd5, b: 1'b0});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hE0, 1'b0);
        idle(3);
        chk("t6_empty", exp_q.size(), 0);
        chk_cnt("t6");

        // frame_start mid-packet with a bad header: one increment only
        send_byte(8'hB0, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_sync++;
        send_byte(8'h00, 1'b1);
        idle(2);
        chk_cnt("t7");

        // Randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            wait_drain();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bb = 8'($urandom);
                if (bb[7:5] == 3'b101) bb[7:5] = 3'b011;
                exp_sync++;
                send_byte(bb, 1'b0);
            end else if (r == 1) begin
                w = enc(1'($urandom), 3'($urandom), 10'($urandom), 10'($urandom), 5'($urandom));
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) send_byte(w[31-8*j -: 8], 1'b0);
                exp_sync++;
                pulse_fs();
            end else begin
                send_pkt(1'($urandom), 3'($urandom), $urandom_range(0, 700),
                         $urandom_range(0, 520), 5'($urandom), $urandom_range(0, 3));
            end
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        wr_ready   = 1'b1;
        idle(10);
        chk("rand_empty", exp_q.size(), 0);
        chk_cnt("rand");

        // Saturation of the sync counter
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h00, 1'b0);
            exp_sync++;
        end
        idle(2);
        chk_cnt("sat");

        // Asynchronous reset while a request is held
        wr_ready = 1'b0;
        send_pkt(1'b1, 3'd6, 7, 8, 5'd0, 0);
        idle(2);
        chk("pre_rst_valid", int'(wr_valid), 1);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(wr_valid), 0);
        chk("arst_x", int'(wr_x), 0);
        chk("arst_sync", int'(sync_err_cnt), 0);
        chk("arst_drop", int'(drop_cnt), 0);
        exp_q.delete();
        exp_sync = 0;
        exp_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en   = 1'b1;
        wr_ready = 1'b1;
        send_pkt(1'b1, 3'd1, 1, 2, 5'd0, 0);
        idle(3);
        chk("post_rst_empty", exp_q.size(), 0);
        chk_cnt("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
